// File: rtl/can_tx_scheduler.sv
// Lowest-CAN-ID arbiter that shares one can_controller transmitter among NUM_REQ requesters, plus a one-deep receive register.
// Optional BUSY-phase watchdog with sticky wdog_trip output: define CAN_SCHED_WATCHDOG_EN.
module can_tx_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int FRAME_W  = 108,
  parameter int START_TO = 255
) (
  input  logic                       GCLK,
  input  logic                       RES,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*FRAME_W-1:0] req_frame,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_err,
  output logic                       busy,
  output logic [FRAME_W-1:0]         can_din,
  output logic                       can_tx_start,
  input  logic                       can_tx_ready,
  input  logic [FRAME_W-1:0]         can_dout,
  input  logic                       can_rx_ready,
  output logic [FRAME_W-1:0]         rx_frame,
  output logic                       rx_valid,
  input  logic                       rx_ack,
  output logic                       rx_overrun
`ifdef CAN_SCHED_WATCHDOG_EN
  ,
  output logic                       wdog_trip
`endif
);

  localparam int ID_W  = 11;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(START_TO + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_win_idx;
  logic [CNT_W-1:0]     r_to_cnt;
  logic [FRAME_W-1:0]   r_din;
  logic                 r_tx_start;
  logic                 r_busy;
  logic [NUM_REQ-1:0]   r_req_done;
  logic [NUM_REQ-1:0]   r_req_err;
`ifdef CAN_SCHED_WATCHDOG_EN
  logic [19:0]          r_wdog;
  logic                 r_wdog_trip;
`endif

  logic                 r_rx_ready_q;
  logic [FRAME_W-1:0]   r_rx_frame;
  logic                 r_rx_valid;
  logic                 r_rx_overrun;

  logic [ID_W-1:0]      w_ids [NUM_REQ];
  logic                 w_any;
  logic [IDX_W-1:0]     w_win_idx;
  logic [ID_W-1:0]      w_win_id;
  logic [FRAME_W-1:0]   w_win_frame;
  logic                 w_rx_edge;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_id
    assign w_ids[g] = req_frame[g*FRAME_W + FRAME_W - 1 -: ID_W];
  end

  // Lowest ID among valid requesters; strict compare keeps the lower index on ties.
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    w_win_id  = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_idx = (req_valid[i] && (!w_any || (w_ids[i] < w_win_id))) ? IDX_W'(i)  : w_win_idx;
      w_win_id  = (req_valid[i] && (!w_any || (w_ids[i] < w_win_id))) ? w_ids[i]  : w_win_id;
      w_any     = w_any | req_valid[i];
    end
  end

  assign w_win_frame = req_frame[w_win_idx*FRAME_W +: FRAME_W];

  // Transmit sequencer: arbitration, start/ready handshake, completion pulses.
  always_ff @(posedge GCLK) begin
    if (RES) begin
      r_state    <= S_IDLE;
      r_win_idx  <= '0;
      r_to_cnt   <= '0;
      r_din      <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_req_done <= '0;
      r_req_err  <= '0;
`ifdef CAN_SCHED_WATCHDOG_EN
      r_wdog      <= 20'd0;
      r_wdog_trip <= 1'b0;
`endif
    end else begin
      r_req_done <= '0;
      r_req_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if ((|req_valid) && can_tx_ready) begin
            r_state <= S_ARB;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ARB: begin
          if (w_any) begin
            r_win_idx  <= w_win_idx;
            r_din      <= w_win_frame;
            r_busy     <= 1'b1;
            r_tx_start <= 1'b1;
            r_to_cnt   <= '0;
            r_state    <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_START: begin
          if (!can_tx_ready) begin
            r_tx_start <= 1'b0;
`ifdef CAN_SCHED_WATCHDOG_EN
            r_wdog     <= 20'd0;
`endif
            r_state    <= S_BUSY;
          end else if (r_to_cnt == CNT_W'(START_TO - 1)) begin
            // Controller never acknowledged the start request.
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_req_err  <= ONE_HOT0 << r_win_idx;
            r_state    <= S_ERR;
          end else begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
          end
        end
        S_BUSY: begin
          if (can_tx_ready) begin
            r_busy     <= 1'b0;
            r_req_done <= ONE_HOT0 << r_win_idx;
            r_state    <= S_DONE;
`ifdef CAN_SCHED_WATCHDOG_EN
          end else if (r_wdog == 20'hFFFFF) begin
            r_busy      <= 1'b0;
            r_req_err   <= ONE_HOT0 << r_win_idx;
            r_wdog_trip <= 1'b1;
            r_state     <= S_ERR;
          end else begin
            r_wdog <= r_wdog + 20'd1;
          end
`else
          end else begin
            r_state <= S_BUSY;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_tx_start <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign w_rx_edge = can_rx_ready & ~r_rx_ready_q;

  // Receive capture on rx_ready rising edge; a new frame outranks a same-cycle ack.
  always_ff @(posedge GCLK) begin
    if (RES) begin
      r_rx_ready_q <= 1'b0;
      r_rx_frame   <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_ready_q <= can_rx_ready;
      if (w_rx_edge) begin
        r_rx_frame   <= can_dout;
        r_rx_valid   <= 1'b1;
        r_rx_overrun <= r_rx_overrun | (r_rx_valid & ~rx_ack);
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end else begin
        r_rx_valid <= r_rx_valid;
      end
    end
  end

  assign req_done     = r_req_done;
  assign req_err      = r_req_err;
  assign busy         = r_busy;
  assign can_din      = r_din;
  assign can_tx_start = r_tx_start;
  assign rx_frame     = r_rx_frame;
  assign rx_valid     = r_rx_valid;
  assign rx_overrun   = r_rx_overrun;
`ifdef CAN_SCHED_WATCHDOG_EN
  assign wdog_trip    = r_wdog_trip;
`endif

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Scoreboard bench for can_tx_scheduler: expected grant order comes from sorting (ID, index) keys; a monitor pops on done/err and rx captures.
module tb_can_tx_scheduler;

  localparam int NR  = 4;
  localparam int FW  = 108;
  localparam int STO = 8;

  logic                 GCLK = 1'b0;
  logic                 RES;
  logic [NR-1:0]        req_valid;
  logic [NR*FW-1:0]     req_frame;
  logic [NR-1:0]        req_done;
  logic [NR-1:0]        req_err;
  logic                 busy;
  logic [FW-1:0]        can_din;
  logic                 can_tx_start;
  logic                 can_tx_ready;
  logic [FW-1:0]        can_dout;
  logic                 can_rx_ready;
  logic [FW-1:0]        rx_frame;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 rx_overrun;

  can_tx_scheduler #(.NUM_REQ(NR), .FRAME_W(FW), .START_TO(STO)) dut (
    .GCLK(GCLK), .RES(RES),
    .req_valid(req_valid), .req_frame(req_frame),
    .req_done(req_done), .req_err(req_err), .busy(busy),
    .can_din(can_din), .can_tx_start(can_tx_start), .can_tx_ready(can_tx_ready),
    .can_dout(can_dout), .can_rx_ready(can_rx_ready),
    .rx_frame(rx_frame), .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_overrun(rx_overrun)
  );

  always #5 GCLK = ~GCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { int idx; bit is_err; logic [FW-1:0] frame; } tx_exp_t;
  typedef struct { logic [FW-1:0] frame; bit ovr; } rx_exp_t;
  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];

  function automatic logic [FW-1:0] rand_frame(input logic [10:0] id);
    logic [127:0] t;
    logic [FW-1:0] f;
    t = {$urandom, $urandom, $urandom, $urandom};
    f = t[FW-1:0];
    f[FW-1 -: 11] = id;
    return f;
  endfunction

  // Controller model: drops ready 0..4 cycles after start, holds it low a while, then returns to idle.
  bit ctl_hang = 1'b0;
  int ctl_busy_min = 1;
  int ctl_busy_max = 6;
  initial begin
    can_tx_ready = 1'b1;
    forever begin
      @(negedge GCLK);
      if (can_tx_start && !ctl_hang) begin
        repeat ($urandom_range(0, 4)) @(negedge GCLK);
        can_tx_ready = 1'b0;
        repeat ($urandom_range(ctl_busy_min, ctl_busy_max)) @(negedge GCLK);
        can_tx_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT reports a completion or a capture.
  int start_cycles = 0;
  always @(negedge GCLK) begin
    tx_exp_t e;
    rx_exp_t r;
    if (RES) begin
      start_cycles = 0;
    end else begin
      if (can_tx_start) start_cycles++;
      if ((|req_done) || (|req_err)) begin
        if (tx_q.size() == 0) begin
          chk("unexpected_tx_event", 128'({req_done, req_err}), 128'd0);
        end else begin
          e = tx_q.pop_front();
          chk(e.is_err ? "err_pulse" : "done_pulse", 128'(e.is_err ? req_err : req_done), 128'(4'b0001 << e.idx));
          chk("other_pulse", 128'(e.is_err ? req_done : req_err), 128'd0);
          chk("din_at_completion", 128'(can_din), 128'(e.frame));
          chk("busy_at_completion", 128'(busy), 128'd0);
          if (e.is_err) chk("start_cycles_timeout", 128'(start_cycles), 128'(STO));
          else chk("start_cycles_ok", 128'((start_cycles >= 1) && (start_cycles <= 5)), 128'd1);
        end
        start_cycles = 0;
      end
      if (rx_q.size() != 0) begin
        r = rx_q.pop_front();
        chk("rx_valid", 128'(rx_valid), 128'd1);
        chk("rx_frame", 128'(rx_frame), 128'(r.frame));
        chk("rx_overrun", 128'(rx_overrun), 128'(r.ovr));
      end
    end
  end

  task automatic do_round(input logic [NR-1:0] mask, input logic [NR*11-1:0] ids, input bit hang, input bit chk_lat);
    int keys[$];
    int guard;
    int idx;
    tx_exp_t e;
    logic [FW-1:0] first_frame;
    repeat (3) @(negedge GCLK);
    guard = 0;
    while (!can_tx_ready && guard < 200) begin
      @(negedge GCLK);
      guard++;
    end
    ctl_hang = hang;
    for (int i = 0; i < NR; i++) begin
      if (mask[i]) begin
        req_frame[i*FW +: FW] = rand_frame(ids[i*11 +: 11]);
        keys.push_back(int'(ids[i*11 +: 11]) * NR + i);
      end
    end
    keys.sort();
    for (int k = 0; k < keys.size(); k++) begin
      idx = keys[k] % NR;
      e.idx = idx;
      e.is_err = hang;
      e.frame = req_frame[idx*FW +: FW];
      tx_q.push_back(e);
    end
    first_frame = req_frame[(keys[0] % NR)*FW +: FW];
    req_valid = mask;
    if (chk_lat) begin
      @(negedge GCLK);
      chk("tx_start_after_1", 128'(can_tx_start), 128'd0);
      @(negedge GCLK);
      chk("tx_start_after_2", 128'(can_tx_start), 128'd1);
      chk("busy_at_start", 128'(busy), 128'd1);
      chk("din_at_grant", 128'(can_din), 128'(first_frame));
    end
    guard = 0;
    while (req_valid != '0 && guard < 2000) begin
      @(negedge GCLK);
      if (can_tx_start && tx_q.size() > 0)
        req_frame[tx_q[0].idx*FW +: FW] = rand_frame(11'h000);
      req_valid = req_valid & ~(req_done | req_err);
      guard++;
    end
    if (req_valid != '0) begin
      chk("round_timeout", 128'(req_valid), 128'd0);
      tx_q.delete();
      req_valid = '0;
    end
    ctl_hang = 1'b0;
  endtask

  logic [FW-1:0] m_rx_frame;
  bit m_rx_valid;
  bit m_rx_ovr;

  task automatic rx_edge(input logic [FW-1:0] f, input bit ack);
    rx_exp_t r;
    int hold;
    @(negedge GCLK);
    can_dout = f;
    can_rx_ready = 1'b1;
    rx_ack = ack;
    if (m_rx_valid && !ack) m_rx_ovr = 1'b1;
    m_rx_valid = 1'b1;
    m_rx_frame = f;
    @(posedge GCLK);
    r.frame = f;
    r.ovr = m_rx_ovr;
    rx_q.push_back(r);
    @(negedge GCLK);
    rx_ack = 1'b0;
    can_dout = rand_frame(11'($urandom));
    hold = $urandom_range(0, 2);
    repeat (hold) @(negedge GCLK);
    can_rx_ready = 1'b0;
  endtask

  task automatic rx_ack_only();
    @(negedge GCLK);
    rx_ack = 1'b1;
    @(negedge GCLK);
    rx_ack = 1'b0;
    m_rx_valid = 1'b0;
    chk("rx_valid_after_ack", 128'(rx_valid), 128'd0);
    chk("rx_frame_held", 128'(rx_frame), 128'(m_rx_frame));
    chk("rx_overrun_sticky", 128'(rx_overrun), 128'(m_rx_ovr));
  endtask

  initial begin
    logic [NR*11-1:0] ids;
    logic [FW-1:0] lol;
    int guard;
    RES = 1'b1;
    req_valid = '0;
    req_frame = '0;
    can_dout = '0;
    can_rx_ready = 1'b0;
    rx_ack = 1'b0;
    m_rx_frame = '0;
    m_rx_valid = 1'b0;
    m_rx_ovr = 1'b0;
    repeat (3) @(negedge GCLK);
    chk("reset_outputs", 128'({req_done, req_err, busy, can_tx_start, rx_valid, rx_overrun}), 128'd0);
    chk("reset_din", 128'(can_din), 128'd0);
    chk("reset_rx_frame", 128'(rx_frame), 128'd0);
    RES = 1'b0;

    ids = '0; ids[2*11 +: 11] = 11'h123;
    do_round(4'b0100, ids, 1'b0, 1'b1);
    ids = '0; ids[0 +: 11] = 11'h400; ids[11 +: 11] = 11'h0F0; ids[33 +: 11] = 11'h0F1;
    do_round(4'b1011, ids, 1'b0, 1'b1);
    ids = '0; ids[0 +: 11] = 11'h055; ids[22 +: 11] = 11'h055;
    do_round(4'b0101, ids, 1'b0, 1'b1);
    ids = '0; ids[2*11 +: 11] = 11'h200;
    do_round(4'b0100, ids, 1'b1, 1'b1);
    ids = '0; ids[0 +: 11] = 11'h010;
    do_round(4'b0001, ids, 1'b0, 1'b1);

    lol = '0;
    lol[23:0] = 24'h4C4F4C;
    rx_edge(lol, 1'b0);
    rx_edge(rand_frame(11'h321), 1'b0);
    rx_edge(rand_frame(11'h0AA), 1'b1);
    rx_ack_only();

    fork
      begin
        for (int r = 0; r < 25; r++) begin
          for (int i = 0; i < NR; i++)
            ids[i*11 +: 11] = ($urandom_range(0, 2) == 0) ? 11'($urandom_range(0, 3)) : 11'($urandom);
          do_round(4'($urandom_range(1, 15)), ids, 1'($urandom_range(0, 5) == 0), 1'b0);
        end
      end
      begin
        for (int r = 0; r < 20; r++) begin
          repeat ($urandom_range(1, 8)) @(negedge GCLK);
          rx_edge(rand_frame(11'($urandom)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 2) == 0) rx_ack_only();
        end
      end
    join

    // Reset during a long controller busy phase must swallow the completion.
    rx_edge(rand_frame(11'h111), 1'b0);
    ctl_busy_min = 25;
    ctl_busy_max = 25;
    repeat (3) @(negedge GCLK);
    req_frame[FW +: FW] = rand_frame(11'h077);
    req_valid = 4'b0010;
    guard = 0;
    while (can_tx_ready && guard < 50) begin
      @(negedge GCLK);
      guard++;
    end
    chk("controller_went_busy", 128'(can_tx_ready), 128'd0);
    @(negedge GCLK);
    RES = 1'b1;
    @(negedge GCLK);
    RES = 1'b0;
    req_valid = '0;
    m_rx_valid = 1'b0;
    m_rx_ovr = 1'b0;
    m_rx_frame = '0;
    chk("rst_mid_busy_ctl", 128'({can_tx_start, busy, req_done, req_err}), 128'd0);
    chk("rst_mid_busy_rx", 128'({rx_valid, rx_overrun}), 128'd0);
    chk("rst_mid_busy_din", 128'(can_din), 128'd0);
    repeat (40) @(negedge GCLK);
    ctl_busy_min = 1;
    ctl_busy_max = 6;

    ids = '0; ids[3*11 +: 11] = 11'h001; ids[1*11 +: 11] = 11'h002;
    do_round(4'b1010, ids, 1'b0, 1'b1);
    repeat (5) @(negedge GCLK);
    chk("tx_scoreboard_drained", 128'(tx_q.size()), 128'd0);
    chk("rx_scoreboard_drained", 128'(rx_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
